// File: rtl/tx_piso_serializer_pkg.sv
// tx_piso_serializer_pkg: shared TX word width, K28.5 comma constants and serializer FSM states
package tx_piso_serializer_pkg;
   localparam int TX_WIDTH = 10;
   localparam logic [TX_WIDTH-1:0] K28_5_RDN = 10'h0FA;
   localparam logic [TX_WIDTH-1:0] K28_5_RDP = 10'h305;
   typedef enum logic {SYNC, RUN} tx_state_t;
endpackage

// File: rtl/tx_hold_reg.sv
// tx_hold_reg: single-entry holding register with full flag between encoder handshake and shifter
module tx_hold_reg
   import tx_piso_serializer_pkg::*;
#(
   parameter int WIDTH = TX_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full
);
   logic [WIDTH-1:0] r_data;
   logic             r_full;
   // capture on push; a push wins over a pop so the flag never drops a just-written word
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_data <= '0;
         r_full <= 1'b0;
      end else begin
         if (i_push) r_data <= i_data;
         r_full <= i_push | (r_full & ~i_pop);
      end
   assign o_data = r_data;
   assign o_full = r_full;
endmodule

// File: rtl/tx_piso_serializer.sv
// tx_piso_serializer: LSB-first PISO with SYNC comma preamble and idle insertion on underrun
module tx_piso_serializer
   import tx_piso_serializer_pkg::*;
#(
   parameter int               WIDTH      = TX_WIDTH,
   parameter logic [WIDTH-1:0] IDLE_WORD  = K28_5_RDN,
   parameter int               SYNC_WORDS = 4
) (
   input  logic             BitCLK,
   input  logic             Reset,
   input  logic [WIDTH-1:0] TxParallel_10,
   input  logic             TxValid,
   output logic             TxReady,
   output logic             Serial,
   output logic             WordStrobe,
   output logic             IdleInserted
);
   localparam int BW = $clog2(WIDTH);
   localparam int SW = $clog2(SYNC_WORDS + 1);
   tx_state_t        r_state;
   logic [BW-1:0]    r_bit_cnt;
   logic [SW-1:0]    r_sync_cnt;
   logic [WIDTH-1:0] r_shift;
   logic             r_strobe;
   logic             r_idle;
   logic             w_load;
   logic             w_run;
   logic             w_full;
   logic             w_accept;
   logic             w_pop;
   logic [WIDTH-1:0] w_hold;
   assign w_load   = r_bit_cnt == BW'(WIDTH - 1);
   assign w_run    = r_state == RUN;
   assign TxReady  = w_run && !w_full;
   assign w_accept = TxValid && TxReady;
   assign w_pop    = w_load && w_run && w_full;
   tx_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .clk   (BitCLK),
      .rst_n (Reset),
      .i_push(w_accept),
      .i_pop (w_pop),
      .i_data(TxParallel_10),
      .o_data(w_hold),
      .o_full(w_full)
   );
   // shifter, bit counter and SYNC/RUN FSM; the bit counter resets to the load slot
   always_ff @(posedge BitCLK or negedge Reset)
      if (!Reset) begin
         r_state    <= SYNC;
         r_bit_cnt  <= BW'(WIDTH - 1);
         r_sync_cnt <= '0;
         r_shift    <= '0;
         r_strobe   <= 1'b0;
         r_idle     <= 1'b0;
      end else begin
         r_strobe <= w_load;
         r_idle   <= w_load && w_run && !w_full;
         if (w_load) begin
            r_bit_cnt <= '0;
            r_shift   <= w_pop ? w_hold : IDLE_WORD;
         end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_shift   <= r_shift >> 1;
         end
         if (!w_run && w_load) begin
            r_sync_cnt <= r_sync_cnt + 1'b1;
            if (r_sync_cnt == SW'(SYNC_WORDS - 1)) r_state <= RUN;
         end
      end
   assign Serial       = r_shift[0];
   assign WordStrobe   = r_strobe;
   assign IdleInserted = r_idle;
endmodule

// File: tb/tb_tx_piso_serializer.sv
// tb_tx_piso_serializer: randomized and directed checks against a word-period reference model
module tb_tx_piso_serializer;
   localparam int         W    = 10;
   localparam int         SW   = 4;
   localparam logic [9:0] IDLE = 10'h0FA;
   logic       BitCLK = 1'b0;
   logic       Reset;
   logic [9:0] TxParallel_10;
   logic       TxValid;
   logic       TxReady;
   logic       Serial;
   logic       WordStrobe;
   logic       IdleInserted;
   int checks = 0;
   int failures = 0;
   tx_piso_serializer dut (
      .BitCLK       (BitCLK),
      .Reset        (Reset),
      .TxParallel_10(TxParallel_10),
      .TxValid      (TxValid),
      .TxReady      (TxReady),
      .Serial       (Serial),
      .WordStrobe   (WordStrobe),
      .IdleInserted (IdleInserted)
   );
   always #5 BitCLK = ~BitCLK;
   logic [9:0] hq[$];
   logic [9:0] acc_q[$];
   logic [9:0] cur = '0;
   bit         fl = 0;
   bit         cd = 0;
   bit         m_acc = 0;
   bit         started = 0;
   int         n = 0;
   int         loads = 0;
   int         bidx = 0;
   int         acc_total = 0;
   function automatic bit exp_ready();
      return loads >= SW && hq.size() == 0;
   endfunction
   // reference model: edge n is a load slot when n is a multiple of W; first SW slots are sync idles
   always @(posedge BitCLK or negedge Reset)
      if (!Reset) begin
         n = 0;
         loads = 0;
         hq.delete();
         acc_q.delete();
         started = 0;
         m_acc = 0;
         cur = '0;
         fl = 0;
         cd = 0;
      end else begin
         m_acc = TxValid && exp_ready();
         if (n % W == 0) begin
            if (loads < SW) begin
               cur = IDLE; fl = 0; cd = 0; loads++;
            end else if (hq.size() != 0) begin
               cur = hq.pop_front(); fl = 0; cd = 1;
            end else begin
               cur = IDLE; fl = 1; cd = 0;
            end
         end
         if (m_acc) begin
            hq.push_back(TxParallel_10);
            acc_q.push_back(TxParallel_10);
            acc_total++;
         end
         bidx = n % W;
         n++;
         started = 1;
      end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask
   logic [9:0] rec = '0;
   int         last_s = -1;
   int         recon_idx = 0;
   task automatic tick();
      @(negedge BitCLK);
      if (Reset && started) begin
         check("serial", {31'd0, Serial}, {31'd0, cur[bidx]});
         check("strobe", {31'd0, WordStrobe}, {31'd0, bidx == 0});
         check("idle", {31'd0, IdleInserted}, {31'd0, bidx == 0 && fl});
         check("ready", {31'd0, TxReady}, {31'd0, exp_ready()});
         rec[bidx] = Serial;
         if (WordStrobe) begin
            if (last_s >= 0) check("period", n - last_s, W);
            last_s = n;
         end
         if (bidx == W - 1 && cd) begin
            if (recon_idx < acc_q.size()) check("recon", {22'd0, rec}, {22'd0, acc_q[recon_idx]});
            else check("recon_extra", 1, 0);
            recon_idx++;
         end
      end else begin
         last_s = -1;
         recon_idx = 0;
      end
   endtask
   task automatic present(input logic [9:0] w, input int budget);
      bit ok = 0;
      TxValid = 1'b1;
      TxParallel_10 = w;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         ok = m_acc;
      end
      if (!ok) check("present_timeout", 0, 1);
   endtask
   task automatic check_cleared(input string tag);
      check({tag, "_serial"}, {31'd0, Serial}, 0);
      check({tag, "_ready"}, {31'd0, TxReady}, 0);
      check({tag, "_strobe"}, {31'd0, WordStrobe}, 0);
      check({tag, "_idle"}, {31'd0, IdleInserted}, 0);
   endtask
   initial begin
      int start;
      bit found;
      Reset = 1'b0;
      TxValid = 1'b0;
      TxParallel_10 = '0;
      #3 check_cleared("rst");
      tick();
      tick();
      Reset = 1'b1;
      for (int i = 0; i < 45; i++) tick();
      present(10'h2AA, 30);
      present(10'h155, 30);
      present(10'h3FF, 30);
      TxValid = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      present(10'h123, 30);
      TxValid = 1'b0;
      for (int i = 0; i < 40; i++) tick();
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         found = (n % W == 0) && exp_ready();
         if (!found) tick();
      end
      if (!found) check("slot_timeout", 0, 1);
      TxValid = 1'b1;
      TxParallel_10 = 10'h2C7;
      tick();
      check("slot_acc", {31'd0, m_acc}, 1);
      check("slot_idle", {31'd0, IdleInserted}, 1);
      TxValid = 1'b0;
      for (int i = 0; i < 25; i++) tick();
      present(10'h0A5, 30);
      present(10'h35A, 30);
      TxValid = 1'b0;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         found = bidx == 5 && cd && cur == 10'h0A5 && hq.size() == 1;
         if (!found) tick();
      end
      if (!found) check("midword_timeout", 0, 1);
      #2 Reset = 1'b0;
      #1 check_cleared("async");
      tick();
      tick();
      Reset = 1'b1;
      for (int i = 0; i < 60; i++) tick();
      start = acc_total;
      for (int cyc = 0; cyc < 40000 && acc_total - start < 1000; cyc++) begin
         tick();
         if (m_acc || !TxValid) begin
            TxValid = $urandom_range(0, 3) != 0;
            TxParallel_10 = 10'($urandom_range(0, 1023));
         end
      end
      if (acc_total - start < 1000) check("rand_budget", acc_total - start, 1000);
      TxValid = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      check("drain", recon_idx, acc_q.size());
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
